// File: rtl/branch_predictor.sv
// Decode-stage branch predictor: gshare-indexed 2-bit counter table, direct
// target computation for branches/JAL, and a circular return-address stack.
module branch_predictor #(
  parameter int BHT_ADDR_BITS = 5,
  parameter int GHR_BITS      = 3,
  parameter int RAS_DEPTH     = 4,
  localparam int N  = BHT_ADDR_BITS,
  localparam int GW = (GHR_BITS > 0) ? GHR_BITS : 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          lk_valid,
  input  logic [31:0]   lk_pc,
  input  logic [31:0]   lk_instr,
  output logic          pred_taken,
  output logic [31:0]   pred_target,
  output logic [N-1:0]  lk_idx,
  output logic [GW-1:0] lk_ghr,
  input  logic          up_valid,
  input  logic [N-1:0]  up_idx,
  input  logic [GW-1:0] up_ghr,
  input  logic          up_taken,
  input  logic          up_mispredict,
  output logic [31:0]   stat_branches,
  output logic [31:0]   stat_miss
);

  localparam int BHT_SIZE = 1 << N;
  localparam int PW       = $clog2(RAS_DEPTH);
  localparam int CW       = PW + 1;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [4:0] REG_RA    = 5'd1;

  // Instruction decode
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [2:0]  funct3;
  logic [11:0] imm_i;
  logic [31:0] imm_b;
  logic [31:0] imm_j;
  logic        is_branch;
  logic        is_jal;
  logic        is_jalr;
  logic        is_ret;
  logic        is_call;
  logic        is_swap;

  assign opcode = lk_instr[6:0];
  assign rd     = lk_instr[11:7];
  assign funct3 = lk_instr[14:12];
  assign rs1    = lk_instr[19:15];
  assign imm_i  = lk_instr[31:20];
  assign imm_b  = {{19{lk_instr[31]}}, lk_instr[31], lk_instr[7],
                   lk_instr[30:25], lk_instr[11:8], 1'b0};
  assign imm_j  = {{11{lk_instr[31]}}, lk_instr[31], lk_instr[19:12],
                   lk_instr[20], lk_instr[30:21], 1'b0};

  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR) && (funct3 == 3'b000);
  assign is_ret    = is_jalr && (rd == 5'd0) && (rs1 == REG_RA) && (imm_i == 12'd0);
  assign is_call   = (is_jal || is_jalr) && (rd == REG_RA);
  // Coroutine-style jump through ra: pops the old return and pushes a new one.
  assign is_swap   = is_jalr && (rd == REG_RA) && (rs1 == REG_RA);

  // Global history and table index
  logic [GW-1:0] ghr;
  logic [1:0]    bht [BHT_SIZE];

  assign lk_idx = lk_pc[N+1:2] ^ N'(ghr);
  assign lk_ghr = ghr;

  // Return-address stack
  logic [31:0]   ras [RAS_DEPTH];
  logic [PW-1:0] ras_ptr;
  logic [PW-1:0] top_ptr;
  logic [CW-1:0] ras_cnt;
  logic          ras_empty;
  logic          ras_push;
  logic          ras_pop;
  logic [31:0]   ret_addr;

  assign top_ptr   = ras_ptr - PW'(1);
  assign ras_empty = (ras_cnt == '0);
  assign ret_addr  = lk_pc + 32'd4;
  assign ras_push  = lk_valid && is_call;
  assign ras_pop   = lk_valid && (is_ret || is_swap) && !ras_empty;

  // Prediction
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    pred_taken  = 1'b0;
    pred_target = 32'd0;
    if (lk_valid) begin
      if (is_branch) begin
        pred_taken  = bht[lk_idx][1];
        pred_target = lk_pc + imm_b;
      end else if (is_jal) begin
        pred_taken  = 1'b1;
        pred_target = lk_pc + imm_j;
      end else if (is_ret && !ras_empty) begin
        pred_taken  = 1'b1;
        pred_target = ras[top_ptr];
      end
    end
  end

  // Counter table: lookup reads the pre-edge value, so a same-index update is
  // only visible from the next cycle.
  logic [1:0] ctr_cur;
  logic [1:0] ctr_nxt;

  assign ctr_cur = bht[up_idx];

  always_comb begin
    ctr_nxt = ctr_cur;
    if (up_taken) begin
      if (ctr_cur != 2'b11) ctr_nxt = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != 2'b00) ctr_nxt = ctr_cur - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the counter table is architecturally reset to weakly-not-taken, so
    // it is a register array with a reset loop rather than a plain RAM.
    if (!resetn) begin
      for (int i = 0; i < BHT_SIZE; i++) bht[i] <= 2'b01;
    end else if (up_valid) begin
      bht[up_idx] <= ctr_nxt;
    end
  end

  // History register: recovery from a mispredict overrides speculation.
  generate
    if (GHR_BITS > 0) begin : g_ghr
      always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!resetn) begin
          ghr <= '0;
        end else if (up_valid && up_mispredict) begin
          ghr <= GW'({up_ghr, up_taken});
        end else if (lk_valid && is_branch) begin
          ghr <= GW'({ghr, pred_taken});
        end
      end
    end else begin : g_no_ghr
      logic unused_ghr;
      assign unused_ghr = ^up_ghr;
      assign ghr        = '0;
    end
  endgenerate

  // RAS pointer and occupancy; a push when full wraps over the oldest entry.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (ras_push && ras_pop) begin
      ras_ptr <= ras_ptr;
    end else if (ras_push) begin
      ras_ptr <= ras_ptr + PW'(1);
      if (ras_cnt != CW'(RAS_DEPTH)) ras_cnt <= ras_cnt + CW'(1);
    end else if (ras_pop) begin
      ras_ptr <= top_ptr;
      ras_cnt <= ras_cnt - CW'(1);
    end
  end

  // NOTE: stack storage is never read while empty, so it needs no reset.
  always_ff @(posedge clk) begin
    if (resetn && ras_push) begin
      if (ras_pop) ras[top_ptr] <= ret_addr;
      else         ras[ras_ptr] <= ret_addr;
    end
  end

  // Statistics, free-running modulo 2^32
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stat_branches <= 32'd0;
      stat_miss     <= 32'd0;
    end else if (up_valid) begin
      stat_branches <= stat_branches + 32'd1;
      if (up_mispredict) stat_miss <= stat_miss + 32'd1;
    end
  end

endmodule
